// File: rtl/num_pkg.sv
// num_pkg: shared types and helpers for the num_arbiter arithmetic slice.
//   op_e       : operation code carried with each request
//   wsel_e     : operand/result width selector
//   width_mask : 64-bit mask keeping the low W bits for a given width
//   extend     : sign- or zero-extend a W-bit result held in the low bits
package num_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        OP_PLUS  = 2'b00,
        OP_MINUS = 2'b01,
        OP_MUL   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        W8  = 2'b00,
        W16 = 2'b01,
        W32 = 2'b10,
        W64 = 2'b11
    } wsel_e;

    function automatic logic [DATA_W-1:0] width_mask(input wsel_e wsel);
        case (wsel)
            W8:      return 64'h0000_0000_0000_00FF;
            W16:     return 64'h0000_0000_0000_FFFF;
            W32:     return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Only the low W bits of result are meaningful; the upper bits are
    // rebuilt from the width's top bit (signed) or cleared (unsigned).
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] result,
                                                 input wsel_e             wsel,
                                                 input logic              sgn);
        logic [DATA_W-1:0] mask;
        logic              sign_bit;
        mask = width_mask(wsel);
        case (wsel)
            W8:      sign_bit = result[7];
            W16:     sign_bit = result[15];
            W32:     sign_bit = result[31];
            default: sign_bit = result[63];
        endcase
        if (sgn && sign_bit) begin
            return (result & mask) | ~mask;
        end
        return result & mask;
    endfunction

endpackage

// File: rtl/num_unit.sv
// num_unit: combinational arithmetic core shared by all requesters.
//   op     : in  operation (plus / minus / mul / reserved)
//   wsel   : in  width selector (8/16/32/64)
//   sgn    : in  1 = sign-extend result, 0 = zero-extend
//   a, b   : in  64-bit operands, only the low W bits are used
//   result : out W-bit wrap-around result extended to 64 bits
//   err    : out reserved op seen; result forced to zero
module num_unit
    import num_pkg::*;
(
    input  op_e               op,
    input  wsel_e             wsel,
    input  logic              sgn,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] a_w;
    logic [DATA_W-1:0] b_w;
    logic [DATA_W-1:0] raw;

    // The low W bits of a 64-bit add/sub/mul of masked operands equal the
    // result modulo 2^W, so one full-width datapath serves every width and
    // both signednesses; only the final extension differs.
    always_comb begin
        mask = width_mask(wsel);
        a_w  = a & mask;
        b_w  = b & mask;
        err  = 1'b0;
        raw  = '0;
        case (op)
            OP_PLUS:  raw = a_w + b_w;
            OP_MINUS: raw = a_w - b_w;
            OP_MUL:   raw = a_w * b_w;
            default:  err = 1'b1;
        endcase
        result = err ? '0 : extend(raw, wsel, sgn);
    end

endmodule

// File: rtl/num_arbiter.sv
// num_arbiter: round-robin front end sharing one num_unit between N_REQ
// requesters, with a two-stage pipeline and a backpressured response port.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_req_valid         : per-requester request valid
//   o_req_ready         : one-hot grant (all-zero while stage 1 is blocked)
//   i_req_op/_wsel      : 2 bits per requester
//   i_req_signed        : 1 bit per requester
//   i_req_a/_b          : 64 bits per requester
//   o_rsp_valid/_id/_data/_err, i_rsp_ready : response channel
module num_arbiter
    import num_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [2*N_REQ-1:0]        i_req_op,
    input  logic [2*N_REQ-1:0]        i_req_wsel,
    input  logic [N_REQ-1:0]          i_req_signed,
    input  logic [DATA_W*N_REQ-1:0]   i_req_a,
    input  logic [DATA_W*N_REQ-1:0]   i_req_b,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_rsp_err
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              ld_p2;
    logic              open_p1;
    logic              accept;

    op_e               sel_op;
    wsel_e             sel_wsel;
    logic              sel_sgn;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    logic              vld_p1;
    op_e               op_p1;
    wsel_e             wsel_p1;
    logic              sgn_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [ID_W-1:0]   id_p1;

    logic [DATA_W-1:0] res_u;
    logic              err_u;

    logic              vld_p2;
    logic [ID_W-1:0]   id_p2;
    logic [DATA_W-1:0] data_p2;
    logic              err_p2;

    // S2 takes new contents when empty or when its response is consumed;
    // S1 moves into S2 on the same condition, so S1 is free to accept when
    // it is empty or draining this cycle.
    assign ld_p2   = !vld_p2 || i_rsp_ready;
    assign open_p1 = !vld_p1 || ld_p2;
    assign accept  = gnt_any && open_p1;

    // Round-robin search: first valid at or above the pointer, otherwise the
    // first valid below it.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && (k >= int'(ptr)) && i_req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(k);
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && i_req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(k);
            end
        end
    end

    assign ptr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        o_req_ready = '0;
        if (accept) begin
            o_req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_op   = OP_PLUS;
        sel_wsel = W8;
        sel_sgn  = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == gnt_idx) begin
                sel_op   = op_e'(i_req_op[2*k +: 2]);
                sel_wsel = wsel_e'(i_req_wsel[2*k +: 2]);
                sel_sgn  = i_req_signed[k];
                sel_a    = i_req_a[DATA_W*k +: DATA_W];
                sel_b    = i_req_b[DATA_W*k +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr    <= '0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (accept) begin
                ptr <= ptr_nxt;
            end
            if (open_p1) begin
                vld_p1 <= accept;
            end
            if (ld_p2) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    // ---- stage 1: selected request ----
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_p1   <= sel_op;
            wsel_p1 <= sel_wsel;
            sgn_p1  <= sel_sgn;
            a_p1    <= sel_a;
            b_p1    <= sel_b;
            id_p1   <= gnt_idx;
        end
    end

    num_unit u_unit (
        .op     (op_p1),
        .wsel   (wsel_p1),
        .sgn    (sgn_p1),
        .a      (a_p1),
        .b      (b_p1),
        .result (res_u),
        .err    (err_u)
    );

    // ---- stage 2: result register driving the response port ----
    // Response fields have a defined reset value and only change when a real
    // request moves in, so they stay put across bubbles and stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_p2   <= '0;
            data_p2 <= '0;
            err_p2  <= 1'b0;
        end else if (ld_p2 && vld_p1) begin
            id_p2   <= id_p1;
            data_p2 <= res_u;
            err_p2  <= err_u;
        end
    end

    assign o_rsp_valid = vld_p2;
    assign o_rsp_id    = id_p2;
    assign o_rsp_data  = data_p2;
    assign o_rsp_err   = err_p2;

endmodule

// File: tb/tb_num_arbiter.sv
// tb_num_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (round-robin pointer, in-order response queue).
module tb_num_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    req_op;
    logic [2*N-1:0]    req_wsel;
    logic [N-1:0]      req_signed;
    logic [64*N-1:0]   req_a;
    logic [64*N-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [63:0]       rsp_data;
    logic              rsp_err;

    always #5 clk = ~clk;

    num_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_wsel   (req_wsel),
        .i_req_signed (req_signed),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_data   (rsp_data),
        .o_rsp_err    (rsp_err)
    );

    typedef struct {
        int          id;
        logic [63:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          gnt_log[$];
    int          rsp_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ptr_m   = 0;
    logic [N-1:0] acc_mask;
    logic        refill    = 1'b0;
    logic        rand_mode = 1'b0;
    logic [63:0] last_data;
    logic        last_err;
    int          last_id;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // a op b mod 2^W, then extended: computed in 64 bits and folded to W bits
    // by shifting the result to the top and back.
    function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [1:0] ws,
                                             input logic sg, input logic [63:0] a,
                                             input logic [63:0] b, output logic err);
        int          w;
        logic [63:0] r;
        w   = 8 << ws;
        err = (op == 2'b11);
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a * b;
            default: r = 64'd0;
        endcase
        if (w < 64) begin
            if (sg) r = 64'($signed(r << (64 - w)) >>> (64 - w));
            else    r = (r << (64 - w)) >> (64 - w);
        end
        return r;
    endfunction

    task automatic set_req(input int k, input logic [1:0] op, input logic [1:0] ws,
                           input logic sg, input logic [63:0] a, input logic [63:0] b);
        req_op[2*k +: 2]   = op;
        req_wsel[2*k +: 2] = ws;
        req_signed[k]      = sg;
        req_a[64*k +: 64]  = a;
        req_b[64*k +: 64]  = b;
        req_valid[k]       = 1'b1;
    endtask

    task automatic model_eval();
        int          choice;
        logic [N-1:0] exp_rdy;
        logic        exp_v;
        logic        er;
        exp_t        e;
        choice = -1;
        for (int i = 0; i < N; i++) begin
            if (choice < 0 && req_valid[(ptr_m + i) % N]) choice = (ptr_m + i) % N;
        end
        exp_rdy = '0;
        if (choice >= 0 && !(exp_q.size() >= 2 && !rsp_ready)) exp_rdy[choice] = 1'b1;
        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));

        exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
        check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        if (rsp_valid && exp_q.size() > 0) begin
            check_eq("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
            check_eq("rsp_data", rsp_data, exp_q[0].data);
            check_eq("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
            if (rsp_ready) begin
                last_id   = int'(rsp_id);
                last_data = rsp_data;
                last_err  = rsp_err;
                rsp_log.push_back(int'(rsp_id));
                void'(exp_q.pop_front());
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (e.due < cyc + 1) e.due = cyc + 1;
                    exp_q.push_front(e);
                end
            end
        end

        acc_mask = exp_rdy;
        if (choice >= 0 && exp_rdy != '0) begin
            e.id   = choice;
            e.data = ref_calc(req_op[2*choice +: 2], req_wsel[2*choice +: 2],
                              req_signed[choice], req_a[64*choice +: 64],
                              req_b[64*choice +: 64], er);
            e.err  = er;
            e.due  = cyc + 2;
            exp_q.push_back(e);
            for (int k = 0; k < N; k++) if (req_ready[k]) gnt_log.push_back(k);
            ptr_m = (choice + 1) % N;
        end
    endtask

    task automatic update_reqs();
        for (int k = 0; k < N; k++) begin
            if (acc_mask[k] && !refill) req_valid[k] = 1'b0;
            if (rand_mode && !req_valid[k] && $urandom_range(0, 99) < 50) begin
                set_req(k, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
            end
        end
        if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        model_eval();
        @(posedge clk);
        #1;
        update_reqs();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ptr_m = 0;
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
        check_eq("rst_rsp_data", rsp_data, 64'd0);
        check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || req_valid != '0) && n < 40) begin
            tick();
            n++;
        end
        check_eq("drain_done", 64'(exp_q.size() > 0 || req_valid != '0), 64'd0);
    endtask

    task automatic single(input int k, input logic [1:0] op, input logic [1:0] ws,
                          input logic sg, input logic [63:0] a, input logic [63:0] b);
        rsp_ready = 1'b1;
        set_req(k, op, ws, sg, a, b);
        drain();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        req_wsel   = '0;
        req_signed = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        acc_mask   = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        single(0, 2'b00, 2'b00, 1'b1, 64'h7F, 64'h01);
        check_eq("plus_w8_s", last_data, 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("plus_w8_s_id", 64'(last_id), 64'd0);
        single(0, 2'b00, 2'b00, 1'b0, 64'h7F, 64'h01);
        check_eq("plus_w8_u", last_data, 64'h0000_0000_0000_0080);
        single(1, 2'b01, 2'b01, 1'b0, 64'h0, 64'h1);
        check_eq("minus_w16_u", last_data, 64'h0000_0000_0000_FFFF);
        single(2, 2'b10, 2'b10, 1'b1, 64'h1_0000, 64'h1_0000);
        check_eq("mul_w32_s", last_data, 64'h0);
        single(3, 2'b10, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("mul_w64_u", last_data, 64'h1);
        single(2, 2'b11, 2'b10, 1'b0, 64'd5, 64'd7);
        check_eq("rsvd_data", last_data, 64'h0);
        check_eq("rsvd_err", 64'(last_err), 64'd1);
        check_eq("rsvd_id", 64'(last_id), 64'd2);

        // all requesters streaming
        do_reset();
        gnt_log.delete();
        rsp_log.delete();
        rsp_ready = 1'b1;
        refill    = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 2'b00, 2'b10, 1'b0, 64'(k), 64'd100);
        repeat (8) tick();
        refill    = 1'b0;
        req_valid = '0;
        drain();
        check_eq("rr_gnt_count", 64'(gnt_log.size()), 64'd8);
        check_eq("rr_rsp_count", 64'(rsp_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < gnt_log.size()) check_eq("rr_gnt_order", 64'(gnt_log[i]), 64'(i % 4));
            if (i < rsp_log.size()) check_eq("rr_rsp_order", 64'(rsp_log[i]), 64'(i % 4));
        end

        // backpressure with two in flight
        do_reset();
        rsp_log.delete();
        rsp_ready = 1'b0;
        set_req(0, 2'b00, 2'b00, 1'b0, 64'd1, 64'd2);
        set_req(1, 2'b01, 2'b00, 1'b0, 64'd9, 64'd4);
        set_req(2, 2'b10, 2'b00, 1'b0, 64'd3, 64'd3);
        repeat (2) tick();
        check_eq("stall_ready_zero", 64'(req_ready), 64'd0);
        repeat (3) tick();
        rsp_ready = 1'b1;
        drain();
        check_eq("stall_rsp_count", 64'(rsp_log.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rsp_log.size()) check_eq("stall_rsp_order", 64'(rsp_log[i]), 64'(i));
        end

        // reset with requests in flight, then pointer back at 0
        rsp_ready = 1'b0;
        set_req(0, 2'b00, 2'b01, 1'b0, 64'd10, 64'd20);
        set_req(1, 2'b00, 2'b01, 1'b0, 64'd30, 64'd40);
        repeat (2) tick();
        do_reset();
        rsp_ready = 1'b1;
        gnt_log.delete();
        set_req(3, 2'b00, 2'b00, 1'b0, 64'd1, 64'd1);
        set_req(0, 2'b00, 2'b00, 1'b0, 64'd2, 64'd2);
        tick();
        check_eq("post_rst_gnt_count", 64'(gnt_log.size()), 64'd1);
        if (gnt_log.size() > 0) check_eq("post_rst_gnt", 64'(gnt_log[0]), 64'd0);
        drain();

        // randomized traffic with random backpressure and a mid-run reset
        rand_mode = 1'b1;
        repeat (1500) tick();
        do_reset();
        repeat (1500) tick();
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/num_arbiter.md
# num_arbiter

Shares one registered arithmetic unit (plus, minus, mul) between N_REQ requesters, each selecting 8/16/32/64-bit width and signed/unsigned wrap-around semantics per request. Arbitration is round-robin. The unit is two stages deep with a single response channel that supports backpressure. It sits between client blocks and the arithmetic datapath so that one multiplier/adder serves all clients.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(N_REQ), requester-id width
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  N_REQ  per-requester request valid
- o_req_ready  out  N_REQ  one-hot grant; request k is accepted when i_req_valid[k] && o_req_ready[k]
- i_req_op  in  2*N_REQ  per requester: 00 plus, 01 minus, 10 mul, 11 reserved
- i_req_wsel  in  2*N_REQ  per requester: 00 8-bit, 01 16-bit, 10 32-bit, 11 64-bit
- i_req_signed  in  N_REQ  1 = sign-extend result, 0 = zero-extend result
- i_req_a, i_req_b  in  64*N_REQ  operands
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumer ready
- o_rsp_id  out  ID_W  requester index of the response
- o_rsp_data  out  64  result, extended to 64 bits
- o_rsp_err  out  1  set when the request used the reserved op

## Operation
- Arithmetic: use only the low W bits of a and b (W from wsel). Compute a op b modulo 2^W. Sign-extend the W-bit result to 64 bits if signed, otherwise zero-extend. Signed and unsigned paths share the low-W result; only the extension differs.
- Reserved op: o_rsp_data = 0, o_rsp_err = 1. The request is otherwise handled normally.
- Round-robin arbitration:
  - Priority pointer resets to 0.
  - When requester k is granted, the pointer moves to (k+1) mod N_REQ.
  - The pointer is unchanged on any cycle with no grant.
  - At most one grant per cycle.
- o_req_ready is combinational from i_req_valid, the pointer and the stall condition. It is all-zero when stage 1 cannot advance. Requesters must not make valid depend on ready. A requester holds its request fields stable until accepted.
- Pipeline:
  - S1 registers the selected request: op, wsel, signed, a, b, id.
  - S2 registers the result, id and err, and drives the o_rsp_* outputs.
  - S2 loads when it is empty or (o_rsp_valid && i_rsp_ready).
  - S1 advances when S2 loads; S1 accepts a new request when it is empty or advancing.
- Reset:
  - All valids clear and the pointer returns to 0.
  - o_rsp_valid = 0, o_rsp_id = 0, o_rsp_data = 0, o_rsp_err = 0.
  - In-flight requests are discarded with no response.

## Timing
- Latency: a request accepted at edge t produces o_rsp_valid at t+2 when there is no stall.
- Throughput: one request per cycle with i_rsp_ready held high.
- Stall:
  - While o_rsp_valid && !i_rsp_ready, all S2 outputs hold stable.
  - S1 holds if occupied; o_req_ready goes all-zero once S1 is occupied.
  - Maximum in flight: 2.
- Response drains and acceptance in the same cycle are allowed; the full pipeline keeps streaming.
- Reset asserted mid-stall clears both stages on the next edge, regardless of i_rsp_ready.
- A grant and a response for the same requester in the same cycle are independent events.

## Structure
- Package num_pkg:
  - op_e enum (OP_PLUS, OP_MINUS, OP_MUL, OP_RSVD).
  - wsel_e enum (W8, W16, W32, W64).
  - Function width_mask(wsel_e) returning the 64-bit mask.
  - Function extend(result, wsel_e, signed).
- Sub-module num_unit: purely combinational; op/wsel/signed/a/b in, 64-bit result and err out. It is instantiated once, between S1 and S2.
- num_arbiter contains the pointer, grant logic, S1/S2 registers and handshake.

## Test plan
- Req0 plus, W8, signed, a=0x7F, b=0x01 → at t+2: id 0, data 0xFFFF_FFFF_FFFF_FF80. Same request unsigned → 0x0000_0000_0000_0080.
- Req1 minus, W16, unsigned, a=0x0000, b=0x0001 → 0x0000_0000_0000_FFFF. Req2 mul, W32, signed, a=0x1_0000, b=0x1_0000 → 0. Req3 mul, W64, unsigned, a=b=0xFFFF_FFFF_FFFF_FFFF → 0x1.
- All four requesters valid continuously for 8 cycles, i_rsp_ready=1 → grants 0,1,2,3,0,1,2,3 and responses in the same id order, one per cycle from t+2.
- Accept two requests, then hold i_rsp_ready=0 for 3 cycles → o_req_ready all-zero while full, o_rsp_* stable, both responses delivered in order once ready rises, none lost or duplicated.
- Reserved op (11) from req2 with a=5, b=7 → data 0, err 1, id 2.
- Two requests in flight, assert i_rst for one cycle → o_rsp_valid 0 next cycle, no stale response afterward. The next request from req3 with req0 also valid is granted to req0 (pointer back at 0).
